idecode: RTL and testbench

- Instruction-decode stage directly downstream of instruction fetch.
- Consumes the fetched instruction word (IR) and incremented PC (nPC).
- Contains:
  - a 32x32 register file with a write-back port;
  - an immediate sign-extender;
  - the main control decoder;
  - the ID/EX pipeline register with stall and flush.
- All stage outputs are registered and feed the execute stage.

---
 rtl/idecode.sv | 114 +++++++++++
 tb/tb_idecode.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/idecode.sv
// Instruction-decode stage: 32-entry register file with write-back bypass,
// immediate sign-extension, main control decoder and the ID/EX pipeline register.
module idecode #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         IR,
    input  logic [WIDTH-1:0]         nPC,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [WIDTH-1:0]         wb_data,
    output logic [WIDTH-1:0]         ex_nPC,
    output logic [WIDTH-1:0]         ex_RD1,
    output logic [WIDTH-1:0]         ex_RD2,
    output logic signed [WIDTH-1:0]  ex_imm,
    output logic [4:0]               ex_rt,
    output logic [4:0]               ex_rd,
    output logic [5:0]               ex_funct,
    output logic [9:0]               ex_ctrl
);
    localparam int AW = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control word: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}
    function automatic logic [9:0] decode_ctrl(input logic [5:0] op);
        case (op)
            OP_RTYPE: decode_ctrl = 10'b1001000010;
            OP_LW:    decode_ctrl = 10'b0111100000;
            OP_SW:    decode_ctrl = 10'b0100010000;
            OP_BEQ:   decode_ctrl = 10'b0000001001;
            OP_ADDI:  decode_ctrl = 10'b0101000000;
            OP_J:     decode_ctrl = 10'b0000000100;
            default:  decode_ctrl = 10'b0000000000;
        endcase
    endfunction

    logic [WIDTH-1:0]        regs_q [NREGS];
    logic [AW-1:0]           rs, rt;
    logic                    wb_hit;
    logic [WIDTH-1:0]        rd1_d, rd2_d;
    logic signed [WIDTH-1:0] imm_d;
    logic [9:0]              ctrl_d;

    logic [WIDTH-1:0]        ex_nPC_q, ex_RD1_q, ex_RD2_q;
    logic signed [WIDTH-1:0] ex_imm_q;
    logic [4:0]              ex_rt_q, ex_rd_q;
    logic [5:0]              ex_funct_q;
    logic [9:0]              ex_ctrl_q;

    assign rs     = IR[25:21];
    assign rt     = IR[20:16];
    assign wb_hit = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_hit) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Read ports: register 0 is hard-wired, a same-cycle write-back bypasses the array
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs != '0) rd1_d = (wb_hit && (wb_addr == rs)) ? wb_data : regs_q[rs];
        if (rt != '0) rd2_d = (wb_hit && (wb_addr == rt)) ? wb_data : regs_q[rt];
    end

    assign imm_d  = {{(WIDTH-16){IR[15]}}, IR[15:0]};
    assign ctrl_d = decode_ctrl(IR[31:26]);

    // ID/EX register: flush beats stall beats load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            ex_nPC_q   <= '0;
            ex_RD1_q   <= '0;
            ex_RD2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_funct_q <= '0;
            ex_ctrl_q  <= '0;
        end else if (!stall) begin
            ex_nPC_q   <= nPC;
            ex_RD1_q   <= rd1_d;
            ex_RD2_q   <= rd2_d;
            ex_imm_q   <= imm_d;
            ex_rt_q    <= IR[20:16];
            ex_rd_q    <= IR[15:11];
            ex_funct_q <= IR[5:0];
            ex_ctrl_q  <= ctrl_d;
        end
    end

    assign ex_nPC   = ex_nPC_q;
    assign ex_RD1   = ex_RD1_q;
    assign ex_RD2   = ex_RD2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rt    = ex_rt_q;
    assign ex_rd    = ex_rd_q;
    assign ex_funct = ex_funct_q;
    assign ex_ctrl  = ex_ctrl_q;
endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: reset, bypass, r0, sign-extension, stall/flush, opcode decode.
module tb_idecode;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR, nPC;
    logic        stall, flush, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] ex_nPC, ex_RD1, ex_RD2;
    logic signed [31:0] ex_imm;
    logic [4:0]  ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [9:0]  ex_ctrl;

    int errors = 0;
    int checks = 0;

    localparam logic [9:0] C_R    = 10'b1001000010;
    localparam logic [9:0] C_LW   = 10'b0111100000;
    localparam logic [9:0] C_SW   = 10'b0100010000;
    localparam logic [9:0] C_BEQ  = 10'b0000001001;
    localparam logic [9:0] C_ADDI = 10'b0101000000;
    localparam logic [9:0] C_J    = 10'b0000000100;

    idecode dut (
        .clk(clk), .reset(reset), .IR(IR), .nPC(nPC), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_nPC(ex_nPC), .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_imm(ex_imm),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; IR = '0; nPC = '0; stall = 0; flush = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        #1;
        checks++; if (ex_ctrl !== 10'd0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", ex_ctrl); end
        checks++; if (ex_nPC !== 32'd0) begin errors++; $display("FAIL reset_nPC got=%h exp=0", ex_nPC); end
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset_midcycle();
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h1234; IR = '0;
        step();
        wb_en = 0; IR = 32'h00A53020; nPC = 32'd3;
        step();
        checks++; if (ex_RD1 !== 32'h1234) begin errors++; $display("FAIL pre_reset_RD1 got=%h exp=00001234", ex_RD1); end
        checks++; if (ex_RD2 !== 32'h1234) begin errors++; $display("FAIL pre_reset_RD2 got=%h exp=00001234", ex_RD2); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ex_RD1 !== 32'd0) begin errors++; $display("FAIL async_reset_RD1 got=%h exp=0", ex_RD1); end
        checks++; if (ex_ctrl !== 10'd0) begin errors++; $display("FAIL async_reset_ctrl got=%b exp=0", ex_ctrl); end
        checks++; if (ex_nPC !== 32'd0 || ex_imm !== 32'sd0 || ex_rd !== 5'd0 || ex_funct !== 6'd0)
            begin errors++; $display("FAIL async_reset_fields got nPC=%h imm=%h rd=%0d funct=%h exp=0", ex_nPC, ex_imm, ex_rd, ex_funct); end
        #1 reset = 1'b1;
        step();
        checks++; if (ex_RD1 !== 32'd0) begin errors++; $display("FAIL post_reset_RD1 got=%h exp=0", ex_RD1); end
        checks++; if (ex_ctrl !== C_R) begin errors++; $display("FAIL post_reset_ctrl got=%b exp=%b", ex_ctrl, C_R); end
        checks++; if (ex_rd !== 5'd6 || ex_funct !== 6'h20 || ex_imm !== 32'sh3020 || ex_nPC !== 32'd3)
            begin errors++; $display("FAIL post_reset_fields got rd=%0d funct=%h imm=%h nPC=%h exp rd=6 funct=20 imm=3020 nPC=3", ex_rd, ex_funct, ex_imm, ex_nPC); end
    endtask

    task automatic test_bypass();
        IR = 32'h00600820; nPC = 32'd4;
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        step();
        checks++; if (ex_RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_RD1 got=%h exp=deadbeef", ex_RD1); end
        checks++; if (ex_ctrl !== C_R) begin errors++; $display("FAIL bypass_ctrl got=%b exp=%b", ex_ctrl, C_R); end
        checks++; if (ex_RD2 !== 32'd0 || ex_rd !== 5'd1 || ex_rt !== 5'd0)
            begin errors++; $display("FAIL bypass_fields got RD2=%h rd=%0d rt=%0d exp RD2=0 rd=1 rt=0", ex_RD2, ex_rd, ex_rt); end
        wb_en = 0;
        step();
        checks++; if (ex_RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_x3 got=%h exp=deadbeef", ex_RD1); end
    endtask

    task automatic test_r0();
        IR = 32'h0; wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        checks++; if (ex_RD1 !== 32'd0 || ex_RD2 !== 32'd0)
            begin errors++; $display("FAIL r0_bypass got RD1=%h RD2=%h exp=0", ex_RD1, ex_RD2); end
        wb_en = 0;
        step();
        checks++; if (ex_RD1 !== 32'd0) begin errors++; $display("FAIL r0_read got=%h exp=0", ex_RD1); end
    endtask

    task automatic test_lw();
        IR = 32'h0; wb_en = 1; wb_addr = 5'd2; wb_data = 32'h55AA;
        step();
        wb_en = 0; IR = 32'h8C22FFFC; nPC = 32'd7;
        step();
        checks++; if (ex_imm !== 32'shFFFFFFFC) begin errors++; $display("FAIL lw_imm got=%h exp=fffffffc", ex_imm); end
        checks++; if (ex_rt !== 5'd2) begin errors++; $display("FAIL lw_rt got=%0d exp=2", ex_rt); end
        checks++; if (ex_ctrl !== C_LW) begin errors++; $display("FAIL lw_ctrl got=%b exp=%b", ex_ctrl, C_LW); end
        checks++; if (ex_nPC !== 32'd7) begin errors++; $display("FAIL lw_nPC got=%h exp=7", ex_nPC); end
        checks++; if (ex_RD2 !== 32'h55AA || ex_RD1 !== 32'd0)
            begin errors++; $display("FAIL lw_regs got RD1=%h RD2=%h exp RD1=0 RD2=55aa", ex_RD1, ex_RD2); end
    endtask

    task automatic test_stall_flush();
        IR = 32'h10220003; nPC = 32'd9;
        step();
        checks++; if (ex_ctrl !== C_BEQ) begin errors++; $display("FAIL beq_ctrl got=%b exp=%b", ex_ctrl, C_BEQ); end
        checks++; if (ex_imm !== 32'sd3 || ex_nPC !== 32'd9)
            begin errors++; $display("FAIL beq_fields got imm=%h nPC=%h exp imm=3 nPC=9", ex_imm, ex_nPC); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            IR = (i == 0) ? 32'h8C22FFFC : 32'h00600820;
            nPC = 32'd20 + i;
            wb_en = (i == 0); wb_addr = 5'd7; wb_data = 32'h77;
            step();
            checks++; if (ex_ctrl !== C_BEQ || ex_nPC !== 32'd9 || ex_imm !== 32'sd3 || ex_RD2 !== 32'h55AA || ex_rt !== 5'd2)
                begin errors++; $display("FAIL stall_hold[%0d] got ctrl=%b nPC=%h imm=%h RD2=%h rt=%0d exp ctrl=%b nPC=9 imm=3 RD2=55aa rt=2", i, ex_ctrl, ex_nPC, ex_imm, ex_RD2, ex_rt, C_BEQ); end
        end
        wb_en = 0; flush = 1;
        step();
        checks++; if (ex_ctrl !== 10'd0) begin errors++; $display("FAIL flush_ctrl got=%b exp=0", ex_ctrl); end
        checks++; if (ex_nPC !== 32'd0 || ex_RD1 !== 32'd0 || ex_RD2 !== 32'd0 || ex_imm !== 32'sd0 || ex_rt !== 5'd0 || ex_rd !== 5'd0 || ex_funct !== 6'd0)
            begin errors++; $display("FAIL flush_fields got nPC=%h RD1=%h RD2=%h imm=%h rt=%0d rd=%0d funct=%h exp=0", ex_nPC, ex_RD1, ex_RD2, ex_imm, ex_rt, ex_rd, ex_funct); end
        stall = 0; flush = 0; IR = 32'h00E00820; nPC = 32'd11;
        step();
        checks++; if (ex_RD1 !== 32'h77) begin errors++; $display("FAIL write_during_stall got=%h exp=77", ex_RD1); end
    endtask

    task automatic test_opcodes();
        logic [31:0] irs   [4] = '{32'hAC220004, 32'h20220005, 32'h08000010, 32'hFC000000};
        logic [9:0]  ctrls [4] = '{C_SW, C_ADDI, C_J, 10'd0};
        logic [31:0] imms  [4] = '{32'h4, 32'h5, 32'h10, 32'h0};
        for (int i = 0; i < 4; i++) begin
            IR = irs[i]; nPC = 32'd5;
            step();
            checks++; if (ex_ctrl !== ctrls[i]) begin errors++; $display("FAIL opcode_ctrl[%0d] got=%b exp=%b", i, ex_ctrl, ctrls[i]); end
            checks++; if (ex_imm !== $signed(imms[i]) || ex_nPC !== 32'd5)
                begin errors++; $display("FAIL opcode_fields[%0d] got imm=%h nPC=%h exp imm=%h nPC=5", i, ex_imm, ex_nPC, imms[i]); end
        end
        checks++; if (ex_funct !== 6'd0) begin errors++; $display("FAIL unknown_funct got=%h exp=0", ex_funct); end
    endtask

    initial begin
        test_reset();
        test_reset_midcycle();
        test_bypass();
        test_r0();
        test_lw();
        test_stall_flush();
        test_opcodes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
